// File: rtl/seq_alu.sv
// seq_alu: registered unsigned ALU with valid/ready handshakes on both sides.
//   Add, subtract and compare finish in one cycle. Multiply is an iterative
//   shift-add that takes WIDTH iterations plus one hand-off cycle. A result is
//   held, together with its flags, until the consumer takes it.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   a, b, opcode          operands and op (00 add, 01 sub, 10 cmp, 11 mul)
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   result                2*WIDTH-bit registered result
//   flag_zero, flag_neg   result==0; a<b on subtract
//   busy                  state != IDLE
module seq_alu #(
    parameter int WIDTH = 7,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_zero,
    output logic               flag_neg,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    state_t             state, state_nxt;
    logic               accept;
    logic               mul_last;
    logic [2*WIDTH-1:0] a_ext, b_ext, alu_res;
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && (state == IDLE);
    // cnt reaches WIDTH once every multiplier bit has been consumed; that
    // extra cycle moves the finished accumulator into result.
    assign mul_last  = (cnt == CNT_W'(WIDTH));

    assign a_ext = {{WIDTH{1'b0}}, a};
    assign b_ext = {{WIDTH{1'b0}}, b};

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = a_ext + b_ext;
            OP_SUB:  alu_res = a_ext - b_ext;
            OP_CMP:  alu_res = {{(2*WIDTH-3){1'b0}}, (a > b), (a == b), (a < b)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (opcode == OP_MUL) ? MUL : DONE;
            MUL:  if (mul_last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            flag_zero <= 1'b0;
            flag_neg  <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                if (opcode == OP_MUL) begin
                    acc    <= '0;
                    mcand  <= a_ext;
                    mplier <= b;
                    cnt    <= '0;
                end else begin
                    result    <= alu_res;
                    flag_zero <= (alu_res == '0);
                    flag_neg  <= (opcode == OP_SUB) && (a < b);
                end
            end else if (state == MUL) begin
                if (mul_last) begin
                    result    <= acc;
                    flag_zero <= (acc == '0);
                    flag_neg  <= 1'b0;
                end else begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=7: one-cycle ops, multiply latency,
// backpressure, idle out_ready and asynchronous abort mid-multiply.
module tb_seq_alu;

    localparam int W = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a, b;
    logic [1:0]     opcode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           flag_zero, flag_neg, busy;

    int total = 0;
    int bad   = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_zero(flag_zero), .flag_neg(flag_neg),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands for exactly one accept edge.
    task automatic issue(input logic [1:0] op, input int va, input int vb);
        opcode   = op;
        a        = W'(va);
        b        = W'(vb);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("consume_out_valid", 32'(out_valid), 0);
        chk("consume_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; opcode = 2'b00;
        step(); step();
        chk("rst_result", 32'(result), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({flag_zero, flag_neg}), 0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 1);

        // add 127+127
        issue(2'b00, 127, 127);
        chk("add_out_valid", 32'(out_valid), 1);
        chk("add_result", 32'(result), 254);
        chk("add_zero", 32'(flag_zero), 0);
        chk("add_in_ready", 32'(in_ready), 0);
        consume();

        // sub 5-9 -> -4 in 14 bits
        issue(2'b01, 5, 9);
        chk("sub_neg_result", 32'(result), 32'h3FFC);
        chk("sub_neg_flag", 32'(flag_neg), 1);
        chk("sub_neg_zero", 32'(flag_zero), 0);
        consume();

        // sub 9-9, then hold it under backpressure with stray in_valid
        issue(2'b01, 9, 9);
        chk("sub_zero_result", 32'(result), 0);
        chk("sub_zero_flags", 32'({flag_zero, flag_neg}), 32'b10);
        in_valid = 1'b1; opcode = 2'b00; a = 7'd1; b = 7'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_result", 32'(result), 0);
            chk("bp_zero", 32'(flag_zero), 1);
        end
        in_valid = 1'b0;
        consume();

        // compares
        issue(2'b10, 20, 3);
        chk("cmp_gt", 32'(result), 4);
        chk("cmp_gt_flags", 32'({flag_zero, flag_neg}), 0);
        consume();
        issue(2'b10, 3, 3);
        chk("cmp_eq", 32'(result), 2);
        consume();
        issue(2'b10, 0, 127);
        chk("cmp_lt", 32'(result), 1);
        chk("cmp_lt_neg", 32'(flag_neg), 0);
        consume();

        // out_ready while idle does nothing
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_ready_out_valid", 32'(out_valid), 0);
        chk("idle_ready_busy", 32'(busy), 0);

        // mul 127*127, operands wiggled and in_valid held during iterations
        issue(2'b11, 127, 127);
        in_valid = 1'b1; a = 7'd1; b = 7'd1; opcode = 2'b00;
        for (int i = 1; i <= 7; i++) begin
            chk("mul_busy", 32'(busy), 1);
            chk("mul_in_ready", 32'(in_ready), 0);
            chk("mul_no_valid", 32'(out_valid), 0);
            step();
        end
        chk("mul_pre_done", 32'(out_valid), 0);
        step();
        chk("mul_done_at_8", 32'(out_valid), 1);
        chk("mul_result", 32'(result), 16129);
        chk("mul_flags", 32'({flag_zero, flag_neg}), 0);
        in_valid = 1'b0;
        consume();

        // mul 0*99
        issue(2'b11, 0, 99);
        for (int i = 0; i < 8; i++) step();
        chk("mul0_out_valid", 32'(out_valid), 1);
        chk("mul0_result", 32'(result), 0);
        chk("mul0_zero", 32'(flag_zero), 1);
        consume();

        // mul 5*6 aborted by reset during the third iteration
        issue(2'b11, 5, 6);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_flags", 32'({flag_zero, flag_neg}), 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_abort_no_valid", 32'(out_valid), 0);
        end
        chk("post_abort_in_ready", 32'(in_ready), 1);
        issue(2'b00, 1, 1);
        chk("post_abort_add_valid", 32'(out_valid), 1);
        chk("post_abort_add", 32'(result), 2);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
